program_loader: RTL
===================

Name: program_loader

Overview:
Loads a program into the processor's 32 x 16-bit instruction memory from a host-side valid/ready word stream. It holds the processor in reset while loading and releases it once the last word has committed. It sits between the host/bench and the instruction memory write port. It is the writer counterpart to the processor's instruction fetch (reader).

Parameters:
DATA_W, 16, instruction word width
ADDR_W, 5, instruction memory address width
DEPTH, 32, instruction memory entries (2**ADDR_W)

Ports:
Clk  input  1  system clock, all logic on rising edge
Reset_n  input  1  synchronous active-low reset
Start  input  1  begin a load; sampled in IDLE and DONE only
Count  input  ADDR_W+1  number of words to load; legal 1..DEPTH; sampled with Start
In_Valid  input  1  host word valid
In_Data  input  DATA_W  host instruction word
In_Ready  output  1  loader accepts word; equals (state==LOAD)
Mem_Addr  output  ADDR_W  memory write/read address
Mem_Data  output  DATA_W  memory write data
Mem_WrEn  output  1  one-cycle write strobe
Mem_RdData  input  DATA_W  synchronous-read data, valid 1 cycle after Mem_Addr (used only with verify)
Proc_Reset  output  1  active-high reset to the processor
Busy  output  1  high in LOAD/DRAIN/VERIFY
Done  output  1  high in DONE
Error  output  1  sticky error flag
Checksum  output  DATA_W  mod-2^16 sum of accepted words
StateO  output  3  current state encoding

Behaviour:
- States: IDLE=0, LOAD=1, DRAIN=2, VERIFY=3, DONE=4. All outputs except In_Ready and Busy are registered.
- Reset: Reset_n=0 at a rising edge forces IDLE. Outputs: Proc_Reset=1; Mem_WrEn=0, Mem_Addr=0, Mem_Data=0, Done=0, Error=0, Busy=0, Checksum=0, In_Ready=0.
- Reset mid-operation aborts immediately. Words already written stay in memory; no further Mem_WrEn.
- IDLE:
  - Start=1 with Count in 1..DEPTH: latch Count, clear word counter, clear Checksum, clear Error, go to LOAD.
  - Start=1 with Count=0 or Count>DEPTH: set Error=1 and stay in IDLE.
- LOAD:
  - A handshake is In_Valid & In_Ready at a rising edge.
  - On a handshake: Mem_WrEn=1, Mem_Addr=word counter, Mem_Data=In_Data, and Checksum+=In_Data (carry discarded), all in the next cycle. Then the word counter increments.
  - Mem_WrEn is 0 in any cycle following an edge with no handshake.
  - The handshake that completes Count words moves the state to DRAIN; In_Ready drops in the same cycle.
  - Start is ignored in LOAD, DRAIN and VERIFY.
- DRAIN: one cycle; the final write commits. Mem_WrEn=0. Next state is VERIFY when LOADER_VERIFY_EN is defined, else DONE.
- DONE:
  - Done=1, Proc_Reset=0.
  - Done rises exactly 2 cycles after the final handshake edge. The processor never sees reset released before the last write commits.
  - Start with legal Count: go to LOAD; Proc_Reset=1 and Done=0 from the next cycle.
  - Start with illegal Count: Error=1, stay in DONE.
- Word counter never wraps in use: Count=DEPTH ends at address DEPTH-1.
- Proc_Reset is 1 in every state except DONE.

Optional Feature:
Macro: LOADER_VERIFY_EN.
- Defined:
  - VERIFY drives Mem_Addr=0..Count-1, one address per cycle, Mem_WrEn=0.
  - Mem_RdData is summed one cycle after each address; VERIFY lasts Count+1 cycles.
  - If the read-back sum equals Checksum, go to DONE. Otherwise set Error=1 and go to IDLE, with Proc_Reset held at 1.
- Not defined: no VERIFY state logic; DRAIN goes to DONE; Mem_RdData is unused.

Test Plan:
1. Reset_n=0 for 2 edges -> StateO=0, Proc_Reset=1, In_Ready=0, Mem_WrEn=0, Done=0, Error=0, Checksum=0.
2. Start, Count=3, In_Valid held high with 0x1234, 0x0001, 0xFFFF -> Mem_WrEn pulses in 3 consecutive cycles.
   - Addresses/data: addr 0/0x1234, 1/0x0001, 2/0xFFFF.
   - Checksum=0x1234.
   - Done=1 and Proc_Reset=0 two cycles after the third handshake.
3. Count=4 with In_Valid low on alternate cycles -> writes only follow handshakes; addresses 0..3 contiguous; Done after the 4th word.
4. Start with Count=0, then Count=33 -> Error=1, StateO=0 both times. Then Start with Count=1 -> Error clears and LOAD is entered.
5. Count=5, Reset_n=0 after the 2nd handshake -> exactly 2 Mem_WrEn pulses total; IDLE with Proc_Reset=1.
6. Count=32, then reload from DONE with Count=1 -> last write of the first load at addr 31. Proc_Reset reasserts on the reload. The single write goes to addr 0. With LOADER_VERIFY_EN and a corrupted Mem_RdData word, Error=1 and StateO=0.

Source files
------------

// File: rtl/program_loader.sv
// Streams a program into the 32 x 16-bit instruction memory and holds the processor in reset until the last word commits.
// Optional read-back verification of the loaded image is enabled by defining LOADER_VERIFY_EN.
module program_loader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic [ADDR_W:0]   Count,
    input  logic              In_Valid,
    input  logic [DATA_W-1:0] In_Data,
    output logic              In_Ready,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [DATA_W-1:0] Mem_Data,
    output logic              Mem_WrEn,
    input  logic [DATA_W-1:0] Mem_RdData,
    output logic              Proc_Reset,
    output logic              Busy,
    output logic              Done,
    output logic              Error,
    output logic [DATA_W-1:0] Checksum,
    output logic [2:0]        StateO
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        DRAIN  = 3'd2,
        VERIFY = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t state, next_state;

    logic [ADDR_W:0] count_q;
    logic [ADDR_W:0] word_cnt;
    logic            handshake;
    logic            count_ok;
    logic            last_word;
    logic            start_load;
    logic            start_bad;

    assign In_Ready  = (state == LOAD);
    assign Busy      = (state == LOAD) || (state == DRAIN) || (state == VERIFY);
    assign StateO    = state;
    assign handshake = In_Valid && In_Ready;
    assign count_ok  = (Count != '0) && (Count <= (ADDR_W+1)'(DEPTH));
    assign last_word = (word_cnt == count_q - 1'b1);

`ifdef LOADER_VERIFY_EN
    logic [DATA_W-1:0] rd_sum;
    logic              verify_last;
    logic              verify_ok;

    // The last VERIFY cycle sees the read data of address Count-1 directly on Mem_RdData.
    assign verify_last = (word_cnt == count_q);
    assign verify_ok   = ((rd_sum + Mem_RdData) == Checksum);
`else
    logic unused_rd_data;
    assign unused_rd_data = ^Mem_RdData;
`endif

    always_comb begin
        next_state = state;
        start_load = 1'b0;
        start_bad  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (Start) begin
                    if (count_ok) begin
                        next_state = LOAD;
                        start_load = 1'b1;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (handshake && last_word) next_state = DRAIN;
            end
            DRAIN: begin
`ifdef LOADER_VERIFY_EN
                next_state = VERIFY;
`else
                next_state = DONE;
`endif
            end
            VERIFY: begin
`ifdef LOADER_VERIFY_EN
                if (verify_last) next_state = verify_ok ? DONE : IDLE;
`else
                next_state = IDLE;
`endif
            end
            default: next_state = IDLE;
        endcase
    end

    // Done/Proc_Reset follow the next state so both change on the same edge as StateO.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state      <= IDLE;
            count_q    <= '0;
            word_cnt   <= '0;
            Mem_Addr   <= '0;
            Mem_Data   <= '0;
            Mem_WrEn   <= 1'b0;
            Checksum   <= '0;
            Error      <= 1'b0;
            Done       <= 1'b0;
            Proc_Reset <= 1'b1;
`ifdef LOADER_VERIFY_EN
            rd_sum     <= '0;
`endif
        end else begin
            state      <= next_state;
            Mem_WrEn   <= 1'b0;
            Done       <= (next_state == DONE);
            Proc_Reset <= (next_state != DONE);

            if (start_load) begin
                count_q  <= Count;
                word_cnt <= '0;
                Checksum <= '0;
                Error    <= 1'b0;
            end
            if (start_bad) Error <= 1'b1;

            if (handshake) begin
                Mem_WrEn <= 1'b1;
                Mem_Addr <= word_cnt[ADDR_W-1:0];
                Mem_Data <= In_Data;
                Checksum <= Checksum + In_Data;
                word_cnt <= word_cnt + 1'b1;
            end

`ifdef LOADER_VERIFY_EN
            // word_cnt is reused as the VERIFY cycle index; address k is read in cycle k, summed in cycle k+1.
            if (state == DRAIN) begin
                word_cnt <= '0;
                rd_sum   <= '0;
                Mem_Addr <= '0;
            end
            if (state == VERIFY) begin
                word_cnt <= word_cnt + 1'b1;
                if (word_cnt != '0) rd_sum <= rd_sum + Mem_RdData;
                if ((word_cnt + 1'b1) < count_q) Mem_Addr <= word_cnt[ADDR_W-1:0] + 1'b1;
                if (verify_last && !verify_ok) Error <= 1'b1;
            end
`endif
        end
    end

endmodule
